conv_out_packer: RTL and testbench

Parametrised output stage for a convolution layer. It takes the 8-bit (DATA_WIDTH) post-ReLU/max-pool sample stream with sop/eop/sof/eof framing and packs PACK_NUM samples into one wide word. The words go into an internal FIFO, which a DDR writer drains. This block generalises the fixed 8→64 concat FIFO, adding:
- configurable pack ratio, depth and almost-full level;
- partial-word flush at frame or line end;
- per-word frame flags;
- sticky overflow and underflow error reporting.

---
 rtl/conv_out_packer.sv | 200 ++++++++++++++++++++
 tb/tb_conv_out_packer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_packer.sv
// conv_out_packer: packs a framed DATA_WIDTH sample stream into PACK_NUM-lane words,
// flushes partial words on frame (and optionally line) end, and buffers them in a FIFO
// with sticky overflow/underflow reporting.
module conv_out_packer #(
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          PACK_NUM    = 8,
    parameter int unsigned          DEPTH       = 512,
    parameter int unsigned          AFULL_LEVEL = DEPTH / 2,
    parameter int unsigned          LINE_ALIGN  = 0,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DATA_WIDTH-1:0]          data_i,
    input  logic                           data_valid_i,
    input  logic                           sop_i,
    input  logic                           eop_i,
    input  logic                           sof_i,
    input  logic                           eof_i,
    input  logic                           rd_i,
    output logic [DATA_WIDTH*PACK_NUM-1:0] data_o,
    output logic                           data_valid_o,
    output logic                           sof_o,
    output logic                           eof_o,
    output logic                           empty_o,
    output logic                           afull_o,
    output logic [$clog2(DEPTH):0]         usedw_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int unsigned WordW = DATA_WIDTH * PACK_NUM;
    localparam int unsigned LaneW = $clog2(PACK_NUM);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [LaneW-1:0] LastLane = LaneW'(PACK_NUM - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);
    localparam logic [CntW-1:0]  CntAfull = CntW'(AFULL_LEVEL);
    localparam logic [WordW-1:0] PadWord  = {PACK_NUM{PAD_VALUE}};

    // sop_i carries no function here: line starts need no action in the packer.
    logic unused_sop;
    assign unused_sop = sop_i;

    // Packer state; the held word is kept pre-filled with PAD_VALUE so a flush needs no masking.
    logic [LaneW-1:0] lane_q, lane_d;
    logic [WordW-1:0] word_q, word_d;
    logic             sof_acc_q, sof_acc_d;

    logic             wr_req;
    logic [WordW-1:0] wr_word;
    logic [WordW-1:0] word_wr;
    logic             wr_sof;
    logic             wr_eof;

    // FIFO state
    logic [WordW+1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WordW-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             osof_q, osof_d;
    logic             oeof_q, oeof_d;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    // Packer next state: place the sample, decide completion, produce at most one write.
    always_comb begin
        lane_d    = lane_q;
        word_d    = word_q;
        sof_acc_d = sof_acc_q;
        wr_req    = 1'b0;
        wr_word   = word_q;
        wr_sof    = sof_acc_q;
        wr_eof    = 1'b0;
        word_wr   = word_q;
        if (data_valid_i) begin
            if (sof_i && (lane_q != '0)) begin
                // New frame while a partial word is held: flush it, start fresh at lane 0.
                // The new sample's own completion is deferred because only one write fits.
                wr_req                    = 1'b1;
                wr_word                   = word_q;
                wr_sof                    = sof_acc_q;
                wr_eof                    = 1'b0;
                word_d                    = PadWord;
                word_d[0 +: DATA_WIDTH]   = data_i;
                lane_d                    = LaneW'(1);
                sof_acc_d                 = 1'b1;
            end else begin
                word_wr[lane_q*DATA_WIDTH +: DATA_WIDTH] = data_i;
                if ((lane_q == LastLane) || eof_i || ((LINE_ALIGN != 0) && eop_i)) begin
                    wr_req    = 1'b1;
                    wr_word   = word_wr;
                    wr_sof    = sof_acc_q | sof_i;
                    wr_eof    = eof_i;
                    word_d    = PadWord;
                    lane_d    = '0;
                    sof_acc_d = 1'b0;
                end else begin
                    word_d    = word_wr;
                    lane_d    = lane_q + LaneW'(1);
                    sof_acc_d = sof_acc_q | sof_i;
                end
            end
        end
    end

    // Packer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q    <= '0;
            word_q    <= PadWord;
            sof_acc_q <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            word_q    <= word_d;
            sof_acc_q <= sof_acc_d;
        end
    end

    assign full  = (cnt_q == CntFull);
    assign empty = (cnt_q == '0);
    assign wr_en = wr_req && !full;
    assign rd_en = rd_i && !empty;

    // FIFO next state: pointers, occupancy, sticky errors and the registered read port.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        afull_d  = (cnt_q >= CntAfull);
        ovf_d    = ovf_q | (wr_req & full);
        unf_d    = unf_q | (rd_i & empty);
        dvalid_d = rd_en;
        dout_d   = dout_q;
        osof_d   = osof_q;
        oeof_d   = oeof_q;
        if (rd_en) begin
            {osof_d, oeof_d, dout_d} = mem[rd_ptr_q];
        end
    end

    // FIFO control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            osof_q   <= 1'b0;
            oeof_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            osof_q   <= osof_d;
            oeof_q   <= oeof_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {wr_sof, wr_eof, wr_word};
        end
    end

    assign data_o       = dout_q;
    assign data_valid_o = dvalid_q;
    assign sof_o        = osof_q;
    assign eof_o        = oeof_q;
    assign empty_o      = empty;
    assign afull_o      = afull_q;
    assign usedw_o      = cnt_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;

endmodule

// File: tb/tb_conv_out_packer.sv
// Bench for conv_out_packer: three instances share one sample stream (plain, line-aligned,
// and a shallow padded FIFO); a word-level reference model predicts every output each cycle.
module tb_conv_out_packer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] din;
    logic       dv, sop, eop, sof, eof;
    logic       rd     [3];
    logic [63:0] dout  [3];
    logic       dval   [3];
    logic       osof   [3];
    logic       oeof   [3];
    logic       oempty [3];
    logic       oafull [3];
    logic       oovf   [3];
    logic       ounf   [3];
    logic [4:0] usedw  [3];
    logic [2:0] usedw_c;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_out_packer #(.DATA_WIDTH(8), .PACK_NUM(8), .DEPTH(16), .AFULL_LEVEL(8),
                      .LINE_ALIGN(0), .PAD_VALUE(8'h00)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .data_i(din), .data_valid_i(dv), .sop_i(sop),
        .eop_i(eop), .sof_i(sof), .eof_i(eof), .rd_i(rd[0]), .data_o(dout[0]),
        .data_valid_o(dval[0]), .sof_o(osof[0]), .eof_o(oeof[0]), .empty_o(oempty[0]),
        .afull_o(oafull[0]), .usedw_o(usedw[0]), .overflow_o(oovf[0]), .underflow_o(ounf[0]));

    conv_out_packer #(.DATA_WIDTH(8), .PACK_NUM(8), .DEPTH(16), .AFULL_LEVEL(8),
                      .LINE_ALIGN(1), .PAD_VALUE(8'h00)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .data_i(din), .data_valid_i(dv), .sop_i(sop),
        .eop_i(eop), .sof_i(sof), .eof_i(eof), .rd_i(rd[1]), .data_o(dout[1]),
        .data_valid_o(dval[1]), .sof_o(osof[1]), .eof_o(oeof[1]), .empty_o(oempty[1]),
        .afull_o(oafull[1]), .usedw_o(usedw[1]), .overflow_o(oovf[1]), .underflow_o(ounf[1]));

    conv_out_packer #(.DATA_WIDTH(8), .PACK_NUM(8), .DEPTH(4), .AFULL_LEVEL(2),
                      .LINE_ALIGN(0), .PAD_VALUE(8'hE5)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .data_i(din), .data_valid_i(dv), .sop_i(sop),
        .eop_i(eop), .sof_i(sof), .eof_i(eof), .rd_i(rd[2]), .data_o(dout[2]),
        .data_valid_o(dval[2]), .sof_o(osof[2]), .eof_o(oeof[2]), .empty_o(oempty[2]),
        .afull_o(oafull[2]), .usedw_o(usedw_c), .overflow_o(oovf[2]), .underflow_o(ounf[2]));

    assign usedw[2] = {2'b00, usedw_c};

    function automatic int dep_of(int i);
        return (i == 2) ? 4 : 16;
    endfunction
    function automatic int afl_of(int i);
        return (i == 2) ? 2 : 8;
    endfunction
    function automatic bit la_of(int i);
        return (i == 1);
    endfunction
    function automatic logic [7:0] pad_of(int i);
        return (i == 2) ? 8'hE5 : 8'h00;
    endfunction

    // Reference model: samples of the word being assembled, and a word FIFO as a ring.
    logic [7:0]  cur_s [3][8];
    int          cur_n [3];
    bit          cur_sof [3];
    logic [65:0] qm [3][16];
    int          qh [3];
    int          qn [3];
    logic [63:0] e_dout [3];
    bit          e_dval [3], e_sof [3], e_eof [3], e_afull [3], e_ovf [3], e_unf [3];

    function automatic logic [63:0] build(int i);
        logic [63:0] w;
        w = {8{pad_of(i)}};
        for (int j = 0; j < cur_n[i]; j++) w[j*8 +: 8] = cur_s[i][j];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cur_n[i] = 0; cur_sof[i] = 0; qh[i] = 0; qn[i] = 0;
            e_dout[i] = '0; e_dval[i] = 0; e_sof[i] = 0; e_eof[i] = 0;
            e_afull[i] = 0; e_ovf[i] = 0; e_unf[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to that edge.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit          w;
            logic [65:0] wv;
            int          cnt0;
            int          tail;
            w = 0;
            wv = '0;
            if (dv) begin
                if (sof && cur_n[i] > 0) begin
                    wv = {cur_sof[i], 1'b0, build(i)};
                    w = 1;
                    cur_s[i][0] = din; cur_n[i] = 1; cur_sof[i] = 1;
                end else begin
                    cur_s[i][cur_n[i]] = din;
                    cur_n[i]++;
                    cur_sof[i] = cur_sof[i] | sof;
                    if (cur_n[i] == 8 || eof || (la_of(i) && eop)) begin
                        wv = {cur_sof[i], eof, build(i)};
                        w = 1;
                        cur_n[i] = 0; cur_sof[i] = 0;
                    end
                end
            end
            cnt0 = qn[i];
            tail = (qh[i] + qn[i]) % dep_of(i);
            e_afull[i] = (cnt0 >= afl_of(i));
            e_dval[i] = 0;
            if (rd[i]) begin
                if (cnt0 > 0) begin
                    {e_sof[i], e_eof[i], e_dout[i]} = qm[i][qh[i]];
                    e_dval[i] = 1;
                    qh[i] = (qh[i] + 1) % dep_of(i);
                    qn[i]--;
                end else begin
                    e_unf[i] = 1;
                end
            end
            if (w) begin
                if (cnt0 < dep_of(i)) begin
                    qm[i][tail] = wv;
                    qn[i]++;
                end else begin
                    e_ovf[i] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [63:0] o, input logic [63:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[%0d] got %h want %h", tag, i, o, e);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("data_valid", i, 64'(dval[i]), 64'(e_dval[i]));
            chk("data", i, dout[i], e_dout[i]);
            chk("sof", i, 64'(osof[i]), 64'(e_sof[i]));
            chk("eof", i, 64'(oeof[i]), 64'(e_eof[i]));
            chk("usedw", i, 64'(usedw[i]), 64'(qn[i]));
            chk("empty", i, 64'(oempty[i]), 64'(qn[i] == 0));
            chk("afull", i, 64'(oafull[i]), 64'(e_afull[i]));
            chk("overflow", i, 64'(oovf[i]), 64'(e_ovf[i]));
            chk("underflow", i, 64'(ounf[i]), 64'(e_unf[i]));
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic s_op, input logic e_op,
                       input logic s_of, input logic e_of, input logic r0, input logic r1,
                       input logic r2);
        @(negedge clk);
        dv = v; din = d; sop = s_op; eop = e_op; sof = s_of; eof = e_of;
        rd[0] = r0; rd[1] = r1; rd[2] = r2;
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        dv = 0; sop = 0; eop = 0; sof = 0; eof = 0;
        rd[0] = 0; rd[1] = 0; rd[2] = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        din = '0; dv = 0; sop = 0; eop = 0; sof = 0; eof = 0;
        rd[0] = 0; rd[1] = 0; rd[2] = 0;
        model_reset();
        do_reset();

        // 16-sample frame, two full words
        for (int k = 1; k <= 16; k++) cyc(1, 8'(k), 0, 0, k == 1, k == 16, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("w0_data", 0, dout[0], 64'h0807060504030201);
        chk("w0_sof", 0, 64'(osof[0]), 64'd1);
        chk("w0_eof", 0, 64'(oeof[0]), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("w1_data", 0, dout[0], 64'h100F0E0D0C0B0A09);
        chk("w1_sof", 0, 64'(osof[0]), 64'd0);
        chk("w1_eof", 0, 64'(oeof[0]), 64'd1);
        chk("no_underflow", 0, 64'(ounf[0]), 64'd0);

        // Short frame flushed by eof
        cyc(1, 8'hAA, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 8'hBB, 0, 0, 0, 0, 0, 0, 0);
        chk("usedw_before_eof", 0, 64'(usedw[0]), 64'd0);
        cyc(1, 8'hCC, 0, 0, 0, 1, 0, 0, 0);
        chk("usedw_at_eof", 0, 64'(usedw[0]), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("short_data", 0, dout[0], 64'h0000000000CCBBAA);
        chk("short_sof", 0, 64'(osof[0]), 64'd1);
        chk("short_eof", 0, 64'(oeof[0]), 64'd1);
        chk("short_pad_c", 2, dout[2], 64'hE5E5E5E5E5CCBBAA);

        // eop flush only on the line-aligned instance
        for (int k = 1; k <= 8; k++)
            cyc(1, 8'(8'h10 + k), 0, k == 5, k == 1, k == 8, 0, 0, 0);
        chk("la0_usedw", 0, 64'(usedw[0]), 64'd1);
        chk("la1_usedw", 1, 64'(usedw[1]), 64'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("la0_data", 0, dout[0], 64'h1817161514131211);
        chk("la1_data_a", 1, dout[1], 64'h0000001514131211);
        chk("la1_eof_a", 1, 64'(oeof[1]), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("la1_data_b", 1, dout[1], 64'h0000000000181716);
        chk("la1_eof_b", 1, 64'(oeof[1]), 64'd1);

        // Random framed traffic with random reads
        for (int f = 0; f < 24; f++) begin
            int  nl;
            bit  trunc;
            nl = $urandom_range(1, 3);
            trunc = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < nl; l++) begin
                int ll;
                ll = $urandom_range(2, 9);
                for (int s = 0; s < ll; s++) begin
                    if ($urandom_range(0, 3) == 0)
                        cyc(0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
                    cyc(1, 8'($urandom), s == 0, s == ll - 1, (l == 0) && (s == 0),
                        !trunc && (l == nl - 1) && (s == ll - 1),
                        1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
                end
            end
        end
        for (int k = 0; k < 18; k++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);

        // Shallow FIFO: afull timing, saturation and drop
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            cyc(1, 8'(k), 0, 0, k == 1, k == 40, 0, 0, 0);
            if (k == 16) chk("afull_lag", 2, 64'(oafull[2]), 64'd0);
            if (k == 17) chk("afull_rise", 2, 64'(oafull[2]), 64'd1);
        end
        chk("usedw_sat", 2, 64'(usedw[2]), 64'd4);
        chk("overflow_set", 2, 64'(oovf[2]), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("c_word1", 2, dout[2], 64'h0807060504030201);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("c_word4", 2, dout[2], 64'h201F1E1D1C1B1A19);

        // Underflow, then reset mid-frame
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("uf_valid", 2, 64'(dval[2]), 64'd0);
        chk("uf_flag", 2, 64'(ounf[2]), 64'd1);
        for (int k = 1; k <= 3; k++) cyc(1, 8'(8'h20 + k), 0, 0, k == 1, 0, 0, 0, 0);
        do_reset();
        for (int k = 1; k <= 8; k++) cyc(1, 8'(8'h30 + k), 0, 0, k == 1, k == 8, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("post_reset_word", 0, dout[0], 64'h3837363534333231);
        chk("post_reset_sof", 0, 64'(osof[0]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
